// File: rtl/xmpl_dsp_pkg.sv
// Shared types for the DSP frame sequencer: FSM state and error encodings,
// plus small decode helpers used by the top-level FSM.
package xmpl_dsp_pkg;

    localparam int unsigned NUM_STAGES = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CIC  = 3'd1,
        ST_FLT  = 3'd2,
        ST_FFT  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_CIC  = 2'd1,
        ERR_FLT  = 2'd2,
        ERR_FFT  = 2'd3
    } err_e;

    // Error code reported when the given stage's watchdog expires.
    function automatic err_e stage_err(input state_e s);
        case (s)
            ST_CIC:  return ERR_CIC;
            ST_FLT:  return ERR_FLT;
            ST_FFT:  return ERR_FFT;
            default: return ERR_NONE;
        endcase
    endfunction

    // One-hot stage enable vector {fft, flt, cic} for a state.
    function automatic logic [NUM_STAGES-1:0] stage_onehot(input state_e s);
        case (s)
            ST_CIC:  return 3'b001;
            ST_FLT:  return 3'b010;
            ST_FFT:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/xmpl_dsp_tmo_cnt.sv
// Per-stage watchdog: counts cycles spent in the active stage and flags
// expiry on the last allowed cycle. A terminal value of zero disables it.
module xmpl_dsp_tmo_cnt #(
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [TMO_W-1:0] term,
    output logic             expired
);

    localparam logic [TMO_W-1:0] CNT_ZERO = {TMO_W{1'b0}};
    localparam logic [TMO_W-1:0] CNT_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] CNT_MAX  = {TMO_W{1'b1}};

    logic [TMO_W-1:0] cnt_r;

    // Cycle counter, cleared on every state change and saturating so a
    // disabled watchdog never wraps.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r <= CNT_ZERO;
        end else if (clr) begin
            cnt_r <= CNT_ZERO;
        end else if (en && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign expired = en && (term != CNT_ZERO) && (cnt_r == (term - CNT_ONE));

endmodule

// File: rtl/xmpl_dsp_seq.sv
// Frame sequencer: runs CIC, filter and FFT stages in order for a programmed
// number of frames, with a watchdog per stage and abort/restart handling.
module xmpl_dsp_seq
    import xmpl_dsp_pkg::*;
#(
    parameter int FRAME_W = 8,
    parameter int TMO_W   = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [FRAME_W-1:0] n_frames_i,
    input  logic [TMO_W-1:0]   timeout_i,
    input  logic               cic_done_i,
    input  logic               flt_done_i,
    input  logic               fft_done_i,
    output logic               en_cic_o,
    output logic               en_flt_o,
    output logic               en_fft_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [1:0]         err_code_o,
    output logic [FRAME_W-1:0] frame_cnt_o,
    output logic [2:0]         state_o
);

    localparam logic [FRAME_W-1:0] FRM_ZERO = {FRAME_W{1'b0}};
    localparam logic [FRAME_W-1:0] FRM_ONE  = {{(FRAME_W-1){1'b0}}, 1'b1};
    localparam logic [FRAME_W-1:0] FRM_MAX  = {FRAME_W{1'b1}};

    state_e                  state_r, state_nxt_s;
    err_e                    err_code_r, err_code_nxt_s;
    logic [FRAME_W-1:0]      frame_cnt_r, n_frames_r, frame_inc_s;
    logic [TMO_W-1:0]        timeout_r;
    logic [NUM_STAGES-1:0]   en_r;
    logic                    busy_r, done_r, err_r;
    logic                    start_ok_s, accept_s, frame_step_s;
    logic                    in_stage_s, stage_done_s, tmo_exp_s;

    assign start_ok_s  = start_i && (n_frames_i != FRM_ZERO);
    assign in_stage_s  = (state_r == ST_CIC) || (state_r == ST_FLT) || (state_r == ST_FFT);
    assign stage_done_s = ((state_r == ST_CIC) && cic_done_i) ||
                          ((state_r == ST_FLT) && flt_done_i) ||
                          ((state_r == ST_FFT) && fft_done_i);
    assign frame_inc_s = (frame_cnt_r == FRM_MAX) ? frame_cnt_r : (frame_cnt_r + FRM_ONE);

    xmpl_dsp_tmo_cnt #(
        .TMO_W (TMO_W)
    ) u_tmo (
        .clk     (clk_i),
        .reset_n (reset_n_i),
        .clr     (state_nxt_s != state_r),
        .en      (in_stage_s),
        .term    (timeout_r),
        .expired (tmo_exp_s)
    );

    // Next-state decode; abort beats stage done, which beats the watchdog.
    always_comb begin
        state_nxt_s    = state_r;
        err_code_nxt_s = err_code_r;
        accept_s       = 1'b0;
        frame_step_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_ERR: begin
                if (abort_i) begin
                    state_nxt_s    = ST_IDLE;
                    err_code_nxt_s = ERR_NONE;
                end else if (start_ok_s) begin
                    state_nxt_s    = ST_CIC;
                    err_code_nxt_s = ERR_NONE;
                    accept_s       = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_CIC, ST_FLT, ST_FFT: begin
                if (abort_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (stage_done_s) begin
                    if (state_r == ST_CIC) begin
                        state_nxt_s = ST_FLT;
                    end else if (state_r == ST_FLT) begin
                        state_nxt_s = ST_FFT;
                    end else begin
                        frame_step_s = 1'b1;
                        state_nxt_s  = (frame_inc_s == n_frames_r) ? ST_DONE : ST_CIC;
                    end
                end else if (tmo_exp_s) begin
                    state_nxt_s    = ST_ERR;
                    err_code_nxt_s = stage_err(state_r);
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                err_code_nxt_s = ERR_NONE;
            end
        endcase
    end

    // State, run context and outputs, all decoded from the next state so the
    // outputs line up with the state they describe.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r     <= ST_IDLE;
            err_code_r  <= ERR_NONE;
            frame_cnt_r <= FRM_ZERO;
            n_frames_r  <= FRM_ZERO;
            timeout_r   <= {TMO_W{1'b0}};
            en_r        <= {NUM_STAGES{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            err_code_r <= err_code_nxt_s;
            if (accept_s) begin
                n_frames_r  <= n_frames_i;
                timeout_r   <= timeout_i;
                frame_cnt_r <= FRM_ZERO;
            end else if (frame_step_s) begin
                frame_cnt_r <= frame_inc_s;
            end
            en_r   <= stage_onehot(state_nxt_s);
            busy_r <= (state_nxt_s == ST_CIC) || (state_nxt_s == ST_FLT) ||
                      (state_nxt_s == ST_FFT);
            done_r <= (state_nxt_s == ST_DONE);
            err_r  <= (state_nxt_s == ST_ERR);
        end
    end

    assign en_cic_o    = en_r[0];
    assign en_flt_o    = en_r[1];
    assign en_fft_o    = en_r[2];
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign err_o       = err_r;
    assign err_code_o  = err_code_r;
    assign frame_cnt_o = frame_cnt_r;
    assign state_o     = state_r;

endmodule
